// File: rtl/hazard_stall_unit.sv
// Stall-side hazard unit: load-use and branch-in-ID hazard detection, multi-cycle
// stall sequencing, memory-busy freeze, taken-branch flush and stall statistics.
module hazard_stall_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       id_ex_dst_reg,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_dst_reg,
    input  logic             mem_busy,
    input  logic             stat_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       remain_r;
    logic [1:0]       remain_nxt_s;
    logic [1:0]       hazard_n_s;
    logic             stall_s;
    logic             ex_match_s;
    logic             mem_match_s;
    logic [CNT_W-1:0] stall_cycles_r;

    // Register $0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic reg_match(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return (r != 5'd0) && (((r == rs) && uses_rs) || ((r == rt) && uses_rt));
    endfunction

    assign ex_match_s  = reg_match(id_ex_dst_reg, if_id_rs, if_id_rt, id_uses_rs, id_uses_rt);
    assign mem_match_s = reg_match(ex_mem_dst_reg, if_id_rs, if_id_rt, id_uses_rs, id_uses_rt);

    // Hazard length: a branch waiting on a load in EX needs the longest wait.
    always_comb begin
        hazard_n_s = 2'd0;
        if (id_is_branch && id_ex_mem_read && ex_match_s) begin
            hazard_n_s = 2'd2;
        end else if (id_ex_mem_read && ex_match_s) begin
            hazard_n_s = 2'd1;
        end else if (id_is_branch && id_ex_reg_write && ex_match_s) begin
            hazard_n_s = 2'd1;
        end else if (id_is_branch && ex_mem_mem_read && mem_match_s) begin
            hazard_n_s = 2'd1;
        end else begin
            hazard_n_s = 2'd0;
        end
    end

    // Stall sequencer next-state; a memory freeze holds everything in place.
    always_comb begin
        state_nxt_s  = state_r;
        remain_nxt_s = remain_r;
        stall_s      = 1'b0;
        if (mem_busy) begin
            state_nxt_s  = state_r;
            remain_nxt_s = remain_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hazard_n_s != 2'd0) begin
                        stall_s = 1'b1;
                        if (hazard_n_s == 2'd2) begin
                            state_nxt_s  = ST_STALL;
                            remain_nxt_s = hazard_n_s - 2'd1;
                        end else begin
                            state_nxt_s  = ST_RUN;
                            remain_nxt_s = 2'd0;
                        end
                    end else begin
                        state_nxt_s  = ST_RUN;
                        remain_nxt_s = 2'd0;
                    end
                end
                ST_STALL: begin
                    stall_s = 1'b1;
                    if (remain_r <= 2'd1) begin
                        state_nxt_s  = ST_RUN;
                        remain_nxt_s = 2'd0;
                    end else begin
                        state_nxt_s  = ST_STALL;
                        remain_nxt_s = remain_r - 2'd1;
                    end
                end
                default: begin
                    state_nxt_s  = ST_RUN;
                    remain_nxt_s = 2'd0;
                end
            endcase
        end
    end

    // Sequencer state and remaining-cycle register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            remain_r <= 2'd0;
        end else begin
            state_r  <= state_nxt_s;
            remain_r <= remain_nxt_s;
        end
    end

    // Pipeline control outputs: reset forces normal flow, then freeze > stall > flush.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if_id_flush  = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (stall_s) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            if_id_flush = branch_taken;
        end
    end

    // Saturating count of PC-hold cycles; a clear wins over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (stat_clear) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (!pc_write && (stall_cycles_r != {CNT_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall-side partner of the pipeline forwarding logic. Detects hazards that forwarding cannot resolve: load-use, and branch operands resolved in ID. For these it freezes PC and IF/ID and injects bubbles into ID/EX.
- Sequences multi-cycle stalls with a registered counter.
- Handles whole-pipeline freeze while data memory is busy, and IF/ID flush on taken branches.
- Keeps a saturating stall-cycle statistics counter readable by the UART debug path.

Parameters:
- CNT_W, 32, width of the stall-cycle statistics counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- if_id_rs  in  5  rs field of the instruction in ID.
- if_id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID instruction is a branch that compares operands in ID.
- branch_taken  in  1  ID branch resolved taken this cycle.
- id_ex_mem_read  in  1  EX instruction is a load.
- id_ex_reg_write  in  1  EX instruction writes a register.
- id_ex_dst_reg  in  5  EX destination register.
- ex_mem_mem_read  in  1  MEM instruction is a load.
- ex_mem_dst_reg  in  5  MEM destination register.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- stat_clear  in  1  synchronous clear of the statistics counter.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID register may update.
- id_ex_bubble  out  1  load NOP (control bits zero) into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- if_id_flush  out  1  zero IF/ID on the next edge.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- Register match: match(r) = (r != 0) & ((r == if_id_rs & id_uses_rs) | (r == if_id_rt & id_uses_rt)). Register $0 never causes a hazard.
- Hazard cycles N, evaluated combinationally in state RUN. The largest applicable value wins:
  - N=2: id_is_branch & id_ex_mem_read & match(id_ex_dst_reg).
  - N=1: id_ex_mem_read & match(id_ex_dst_reg) (load-use).
  - N=1: id_is_branch & id_ex_reg_write & match(id_ex_dst_reg).
  - N=1: id_is_branch & ex_mem_mem_read & match(ex_mem_dst_reg).
  - Otherwise N=0.
- FSM states: RUN and STALL, plus a 2-bit register remain.
  - RUN with N>0 (and no freeze): stall is asserted in the same cycle. Next state is STALL with remain=N-1 if N=2; otherwise stay in RUN.
  - STALL: stall is asserted unconditionally, with no re-evaluation of hazards. remain decrements each cycle; when remain reaches 0, go to RUN, where hazards are re-evaluated.
- Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
- Freeze, top priority: mem_busy=1 forces pc_write=0, if_id_write=0, pipe_freeze=1, id_ex_bubble=0, if_id_flush=0. FSM state and remain hold unchanged.
- Flush: if_id_flush = branch_taken & no stall & no freeze. A taken branch under stall is not flushed until the stall ends and the branch re-resolves.
- Normal cycle: pc_write=1, if_id_write=1, id_ex_bubble=0, pipe_freeze=0.
- Outputs are combinational from state and inputs; zero latency relative to the hazard.
- stall_cycles:
  - Increments on each clock edge where pc_write=0, including freeze cycles; saturates at all-ones.
  - stat_clear has priority: the counter becomes 0 and that cycle is not counted.
- Reset (asynchronous, any time including mid-stall):
  - state=RUN, remain=0, stall_cycles=0.
  - While rst_n=0, outputs are pc_write=1, if_id_write=1, id_ex_bubble=0, pipe_freeze=0, if_id_flush=0.
  - Stall sequencing restarts from RUN after release.

Test Plan:
- Load-use: EX load dst=5, ID add rs=5 uses_rs=1 → exactly 1 cycle pc_write=0 and id_ex_bubble=1, then normal; stall_cycles=1.
- Branch after load: EX load dst=8, ID beq rt=8 → 2 consecutive stall cycles. The second cycle is in STALL with stimulus unchanged; then RUN; stall_cycles=2.
- Zero register: EX load dst=0, ID rs=0 uses_rs=1 → no stall; pc_write=1 throughout.
- Freeze mid-stall: 2-cycle branch stall with mem_busy=1 for 3 cycles after the first stall cycle → pipe_freeze=1 and id_ex_bubble=0 for those 3 cycles, then 1 remaining stall cycle; stall_cycles=5.
- Taken branch: no hazard, branch_taken=1 → if_id_flush=1 for one cycle. Same stimulus combined with a load-use hazard → if_id_flush=0.
- Async reset during STALL (remain=1): rst_n low mid-cycle → outputs immediately normal, stall_cycles=0. After release with no hazard → RUN, no residual stall. Separately: preload the counter to all-ones and stall → it stays all-ones.
